nrisc_reg_access: RTL

//  Access front-end for the NRISC 16x16 register bank: datapath-side read and write ports.
//  - Turns datapath read requests into registered operand reads: 2 read ports, 1-cycle latency.
//  - Buffers write-backs with a valid/ready handshake and drains them into the bank as one-hot

---
 rtl/nrisc_pkg.sv | 19 +
 rtl/nrisc_wbuf.sv | 91 +++++++++
 rtl/nrisc_reg_access.sv | 116 +++++++++++
 3 files changed

// File: rtl/nrisc_pkg.sv
// Shared sizing defaults and pointer helpers for the NRISC register access front-end.
// No logic of its own; latency and backpressure are defined by the modules that import it.
// Helpers are pure functions usable in constant expressions.
package nrisc_pkg;

    localparam int TAM_DEF        = 16;
    localparam int NREG_DEF       = 16;
    localparam int WBUF_DEPTH_DEF = 2;

    // A 1-entry buffer still needs a 1-bit pointer.
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int wrap_inc(input int p, input int depth);
        return (p + 1 == depth) ? 0 : p + 1;
    endfunction

endpackage

// File: rtl/nrisc_wbuf.sv
// Write-back FIFO with per-entry addr/data/valid and age-ordered taps (tap 0 = oldest).
// Latency: push visible on taps and head the cycle after the push edge.
// Backpressure: caller must not push when full or pop when empty.
module nrisc_wbuf
    import nrisc_pkg::*;
#(
    parameter int TAM   = 16,
    parameter int AW    = 4,
    parameter int DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push,
    input  logic [AW-1:0]        push_addr,
    input  logic [TAM-1:0]       push_data,
    input  logic                 pop,
    output logic                 full,
    output logic                 empty,
    output logic [AW-1:0]        head_addr,
    output logic [TAM-1:0]       head_data,
    output logic [DEPTH-1:0]     tap_vld,
    output logic [DEPTH*AW-1:0]  tap_addr,
    output logic [DEPTH*TAM-1:0] tap_data
);

    localparam int PW = ptr_width(DEPTH);

    logic [AW-1:0]    addr_q [DEPTH];
    logic [AW-1:0]    addr_d [DEPTH];
    logic [TAM-1:0]   data_q [DEPTH];
    logic [TAM-1:0]   data_d [DEPTH];
    logic [DEPTH-1:0] vld_q, vld_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    idx;

    assign full      = &vld_q;
    assign empty     = ~|vld_q;
    assign head_addr = addr_q[rd_ptr_q];
    assign head_data = data_q[rd_ptr_q];

    always_comb begin
        addr_d   = addr_q;
        data_d   = data_q;
        vld_d    = vld_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (pop) begin
            vld_d[rd_ptr_q] = 1'b0;
            rd_ptr_d        = PW'(wrap_inc(int'(rd_ptr_q), DEPTH));
        end
        if (push) begin
            vld_d[wr_ptr_q]  = 1'b1;
            addr_d[wr_ptr_q] = push_addr;
            data_d[wr_ptr_q] = push_data;
            wr_ptr_d         = PW'(wrap_inc(int'(wr_ptr_q), DEPTH));
        end
    end

    // Taps are rotated so that a higher tap index is always a younger entry.
    always_comb begin
        idx      = '0;
        tap_vld  = '0;
        tap_addr = '0;
        tap_data = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx                      = PW'((int'(rd_ptr_q) + k) % DEPTH);
            tap_vld[k]               = vld_q[idx];
            tap_addr[k*AW +: AW]     = addr_q[idx];
            tap_data[k*TAM +: TAM]   = data_q[idx];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            vld_q    <= vld_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        addr_q <= addr_d;
        data_q <= data_d;
    end

endmodule

// File: rtl/nrisc_reg_access.sv
// NRISC register bank front-end: 2 forwarded read ports plus a buffered write-back path.
// Latency: reads 1 cycle; write accept to bank_we at least 1 cycle.
// Backpressure: wr_ready = !full from state only; wb_hold stalls draining, buffer keeps contents.
module nrisc_reg_access
    import nrisc_pkg::*;
#(
    parameter int TAM        = TAM_DEF,
    parameter int NREG       = NREG_DEF,
    parameter int WBUF_DEPTH = WBUF_DEPTH_DEF,
    localparam int AW        = $clog2(NREG)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rd_req,
    input  logic [AW-1:0]       rd_a_addr,
    input  logic [AW-1:0]       rd_b_addr,
    output logic                rd_valid,
    output logic [TAM-1:0]      rd_a_data,
    output logic [TAM-1:0]      rd_b_data,
    input  logic                wr_valid,
    output logic                wr_ready,
    input  logic [AW-1:0]       wr_addr,
    input  logic [TAM-1:0]      wr_data,
    input  logic                wb_hold,
    input  logic [NREG*TAM-1:0] bank_q,
    output logic [NREG-1:0]     bank_we,
    output logic [TAM-1:0]      bank_wdata
);

    logic                      full, empty, push, pop;
    logic [AW-1:0]             head_addr;
    logic [TAM-1:0]            head_data;
    logic [WBUF_DEPTH-1:0]     tap_vld;
    logic [WBUF_DEPTH*AW-1:0]  tap_addr;
    logic [WBUF_DEPTH*TAM-1:0] tap_data;

    logic            rd_valid_q, rd_valid_d;
    logic [TAM-1:0]  rd_a_data_q, rd_a_data_d;
    logic [TAM-1:0]  rd_b_data_q, rd_b_data_d;
    logic [NREG-1:0] bank_we_q, bank_we_d;
    logic [TAM-1:0]  bank_wdata_q, bank_wdata_d;

    assign wr_ready = !rst && !full;
    assign push     = wr_valid && wr_ready;
    assign pop      = !rst && !wb_hold && !empty;

    nrisc_wbuf #(
        .TAM   (TAM),
        .AW    (AW),
        .DEPTH (WBUF_DEPTH)
    ) u_wbuf (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_addr (wr_addr),
        .push_data (wr_data),
        .pop       (pop),
        .full      (full),
        .empty     (empty),
        .head_addr (head_addr),
        .head_data (head_data),
        .tap_vld   (tap_vld),
        .tap_addr  (tap_addr),
        .tap_data  (tap_data)
    );

    // Later assignments win: bank, then older-to-younger buffer entries, then the incoming write.
    function automatic logic [TAM-1:0] fwd(input logic [AW-1:0] a);
        logic [TAM-1:0] v;
        v = bank_q[a*TAM +: TAM];
        for (int k = 0; k < WBUF_DEPTH; k++) begin
            if (tap_vld[k] && tap_addr[k*AW +: AW] == a) v = tap_data[k*TAM +: TAM];
        end
        if (push && wr_addr == a) v = wr_data;
        return v;
    endfunction

    always_comb begin
        rd_valid_d   = rd_req;
        rd_a_data_d  = rd_a_data_q;
        rd_b_data_d  = rd_b_data_q;
        bank_we_d    = '0;
        bank_wdata_d = bank_wdata_q;
        if (rd_req) begin
            rd_a_data_d = fwd(rd_a_addr);
            rd_b_data_d = fwd(rd_b_addr);
        end
        if (pop) begin
            for (int i = 0; i < NREG; i++) bank_we_d[i] = (head_addr == AW'(i));
            bank_wdata_d = head_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid_q   <= 1'b0;
            rd_a_data_q  <= '0;
            rd_b_data_q  <= '0;
            bank_we_q    <= '0;
            bank_wdata_q <= '0;
        end else begin
            rd_valid_q   <= rd_valid_d;
            rd_a_data_q  <= rd_a_data_d;
            rd_b_data_q  <= rd_b_data_d;
            bank_we_q    <= bank_we_d;
            bank_wdata_q <= bank_wdata_d;
        end
    end

    assign rd_valid   = rd_valid_q;
    assign rd_a_data  = rd_a_data_q;
    assign rd_b_data  = rd_b_data_q;
    assign bank_we    = bank_we_q;
    assign bank_wdata = bank_wdata_q;

endmodule
